// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: bundles the lock/request inputs and the staged reset
// outputs of reset_sequencer so the sequencer and its environment share one
// port.
//   locked      lock indication from the clock generator (asynchronous)
//   soft_req    single-cycle software reset request, synchronous to clk
//   rst_out     N_OUT active-high staged resets
//   done        high while every rst_out bit is released
//   relock_cnt  saturating count of lock-loss events
//   fsm_state   current sequencer state, for observation only
// There is no valid/ready pairing here: soft_req is a fire-and-forget pulse
// that is acted on in the cycle it is sampled high, and the outputs are
// level signals that are always valid outside reset.
interface reset_sequencer_if #(
  parameter int N_OUT = 4
);
  logic             locked;
  logic             soft_req;
  logic [N_OUT-1:0] rst_out;
  logic             done;
  logic [7:0]       relock_cnt;
  logic [1:0]       fsm_state;

  // Sequencer side.
  modport master (
    input  locked,
    input  soft_req,
    output rst_out,
    output done,
    output relock_cnt,
    output fsm_state
  );

  // Environment side: clock generator / software and the reset consumers.
  modport slave (
    output locked,
    output soft_req,
    input  rst_out,
    input  done,
    input  relock_cnt,
    input  fsm_state
  );
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer: holds a bank of active-high resets asserted until the
// clock generator's lock has been stable for a filter interval plus a hold
// time, then releases the resets one at a time in index order, spaced by a
// fixed gap. Losing lock or a software request reasserts every output at once.
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset; forces all outputs asserted
//   bus  reset_sequencer_if.master (locked, soft_req in; rst_out, done,
//        relock_cnt, fsm_state out)
module reset_sequencer #(
  parameter int N_OUT       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8
) (
  input logic                clk,
  input logic                rst,
  reset_sequencer_if.master  bus
);

  localparam int CNT_MAX_LH = (LOCK_FILTER > HOLD_CYCLES) ? LOCK_FILTER : HOLD_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_LH > STAGE_GAP) ? CNT_MAX_LH : STAGE_GAP;
  localparam int CW         = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW         = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [CW-1:0] FILTER_LAST = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] IDX_LAST    = IW'(N_OUT - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    STAGE     = 2'd2,
    RUN       = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;

  state_t           state_q, state_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic [IW-1:0]    idx_q, idx_n;
  logic [N_OUT-1:0] rst_out_q, rst_out_n;
  logic             done_q, done_n;
  logic [7:0]       relock_q, relock_n;

  logic lock_lost;

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Lock is only "lost" once we have left WAIT_LOCK; a low lock while still
  // waiting just keeps the filter counter at zero.
  assign lock_lost = !locked_s && (state_q != WAIT_LOCK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      state_q   <= WAIT_LOCK;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '1;
      done_q    <= 1'b0;
      relock_q  <= 8'd0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.locked};
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      idx_q     <= idx_n;
      rst_out_q <= rst_out_n;
      done_q    <= done_n;
      relock_q  <= relock_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    idx_n     = idx_q;
    rst_out_n = rst_out_q;
    done_n    = done_q;
    relock_n  = relock_q;

    if (lock_lost || bus.soft_req) begin
      // A simultaneous lock loss and soft request is one abort and one count.
      state_n   = WAIT_LOCK;
      cnt_n     = '0;
      idx_n     = '0;
      rst_out_n = '1;
      done_n    = 1'b0;
      if (lock_lost && (relock_q != 8'hFF)) begin
        relock_n = relock_q + 8'd1;
      end
    end else begin
      unique case (state_q)
        WAIT_LOCK: begin
          if (!locked_s) begin
            cnt_n = '0;
          end else if (cnt_q == FILTER_LAST) begin
            state_n = HOLD;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_n        = '0;
            rst_out_n[0] = 1'b0;
            if (N_OUT == 1) begin
              state_n = RUN;
              done_n  = 1'b1;
            end else begin
              state_n = STAGE;
              idx_n   = IW'(1);
            end
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
        STAGE: begin
          if (cnt_q == GAP_LAST) begin
            cnt_n = '0;
            for (int k = 0; k < N_OUT; k++) begin
              if (IW'(k) == idx_q) begin
                rst_out_n[k] = 1'b0;
              end
            end
            if (idx_q == IDX_LAST) begin
              state_n = RUN;
              done_n  = 1'b1;
            end else begin
              idx_n = idx_q + 1'b1;
            end
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
        RUN: begin
          rst_out_n = '0;
          done_n    = 1'b1;
        end
        default: begin
          state_n   = WAIT_LOCK;
          cnt_n     = '0;
          idx_n     = '0;
          rst_out_n = '1;
          done_n    = 1'b0;
        end
      endcase
    end
  end

  assign bus.rst_out    = rst_out_q;
  assign bus.done       = done_q;
  assign bus.relock_cnt = relock_q;
  assign bus.fsm_state  = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed bench for reset_sequencer. A timing model
// derived from the release rules (cycles since the hold phase began, compared
// against H + k*G) is checked against the DUT every cycle, and literal edge
// expectations pin the model. A second instance with N_OUT=1, L=1, H=3
// shares the lock input.
module tb_reset_sequencer;

  localparam int S = 2;
  localparam int L = 4;
  localparam int H = 16;
  localparam int G = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  reset_sequencer_if #(.N_OUT(N)) bus ();
  reset_sequencer_if #(.N_OUT(1)) bus1 ();

  assign bus1.locked   = bus.locked;
  assign bus1.soft_req = 1'b0;

  reset_sequencer #(
    .N_OUT(N), .SYNC_STAGES(S), .LOCK_FILTER(L), .HOLD_CYCLES(H), .STAGE_GAP(G)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  reset_sequencer #(
    .N_OUT(1), .SYNC_STAGES(2), .LOCK_FILTER(1), .HOLD_CYCLES(3), .STAGE_GAP(8)
  ) dut_small (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_since: cycles since the hold phase began, -1 while waiting for lock.
  // m_filt : consecutive synchronised-high lock cycles seen while waiting.
  int         m_since  = -1;
  int         m_filt   = 0;
  int         m_relock = 0;
  logic [S-1:0] m_hist = '0;
  logic       m_ls;
  bit         m_lost;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_since  = -1;
      m_filt   = 0;
      m_relock = 0;
      m_hist   = '0;
    end else begin
      m_ls   = m_hist[S-1];
      m_lost = (m_since >= 0) && !m_ls;
      if (m_lost || bus.soft_req) begin
        if (m_lost && m_relock < 255) m_relock++;
        m_since = -1;
        m_filt  = 0;
      end else if (m_since < 0) begin
        m_filt = m_ls ? m_filt + 1 : 0;
        if (m_filt == L) begin
          m_since = 0;
          m_filt  = 0;
        end
      end else if (m_since < 100000) begin
        m_since++;
      end
      m_hist = {m_hist[S-2:0], bus.locked};
    end
  end

  function automatic logic [N-1:0] exp_rst_out(input int since);
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = !(since >= H + k * G);
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_rst_out", 32'(bus.rst_out), 32'(exp_rst_out(m_since)));
      chk("model_done", 32'(bus.done), 32'(m_since >= H + (N - 1) * G));
      chk("model_relock_cnt", 32'(bus.relock_cnt), 32'(m_relock));
    end
  end

  // ---------------- drivers ----------------
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after lock has been (re)driven high; the next edge is edge 1.
  task automatic release_seq(input bit chk_small);
    edges(5);
    if (chk_small) begin
      chk("small_rst_out_e5", 32'(bus1.rst_out), 32'h1);
      chk("small_done_e5", 32'(bus1.done), 32'h0);
    end
    edges(1);
    if (chk_small) begin
      chk("small_rst_out_e6", 32'(bus1.rst_out), 32'h0);
      chk("small_done_e6", 32'(bus1.done), 32'h1);
    end
    edges(15);
    chk("rst_out_e21", 32'(bus.rst_out), 32'hF);
    edges(1);
    chk("rst_out_e22", 32'(bus.rst_out), 32'hE);
    edges(8);
    chk("rst_out_e30", 32'(bus.rst_out), 32'hC);
    edges(7);
    chk("rst_out_e37", 32'(bus.rst_out), 32'hC);
    edges(1);
    chk("rst_out_e38", 32'(bus.rst_out), 32'h8);
    edges(7);
    chk("done_e45", 32'(bus.done), 32'h0);
    edges(1);
    chk("rst_out_e46", 32'(bus.rst_out), 32'h0);
    chk("done_e46", 32'(bus.done), 32'h1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.locked   = 1'b0;
    bus.soft_req = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rst_out", 32'(bus.rst_out), 32'hF);
    chk("reset_done", 32'(bus.done), 32'h0);
    chk("reset_relock", 32'(bus.relock_cnt), 32'h0);
    chk("reset_state", 32'(bus.fsm_state), 32'h0);
    chk("reset_small_rst_out", 32'(bus1.rst_out), 32'h1);
    #3 rst = 1'b0;

    // Power-on release with defaults.
    edges(1);
    bus.locked = 1'b1;
    release_seq(1'b1);
    chk("poweron_relock", 32'(bus.relock_cnt), 32'h0);

    // Lock loss in RUN for five cycles.
    bus.locked = 1'b0;
    edges(1);
    chk("loss_e0_rst_out", 32'(bus.rst_out), 32'h0);
    edges(1);
    chk("loss_e1_rst_out", 32'(bus.rst_out), 32'h0);
    edges(1);
    chk("loss_e2_rst_out", 32'(bus.rst_out), 32'hF);
    chk("loss_e2_done", 32'(bus.done), 32'h0);
    chk("loss_e2_relock", 32'(bus.relock_cnt), 32'h1);
    edges(2);
    bus.locked = 1'b1;
    release_seq(1'b0);

    // Long lock loss, then a 3-cycle glitch before a permanent rise.
    bus.locked = 1'b0;
    edges(6);
    chk("glitch_pre_rst_out", 32'(bus.rst_out), 32'hF);
    chk("glitch_pre_relock", 32'(bus.relock_cnt), 32'h2);
    bus.locked = 1'b1;
    edges(3);
    bus.locked = 1'b0;
    edges(1);
    chk("glitch_no_hold", 32'(bus.fsm_state), 32'h0);
    bus.locked = 1'b1;
    release_seq(1'b0);

    // Soft request in RUN with lock steady.
    bus.soft_req = 1'b1;
    edges(1);
    bus.soft_req = 1'b0;
    chk("soft_rst_out", 32'(bus.rst_out), 32'hF);
    chk("soft_done", 32'(bus.done), 32'h0);
    chk("soft_relock", 32'(bus.relock_cnt), 32'h2);
    edges(19);
    chk("soft_e19_rst_out", 32'(bus.rst_out), 32'hF);
    edges(1);
    chk("soft_e20_rst_out", 32'(bus.rst_out), 32'hE);
    edges(8);
    chk("soft_e28_rst_out", 32'(bus.rst_out), 32'hC);

    // Abort mid-STAGE right after rst_out[1] released.
    bus.locked = 1'b0;
    edges(2);
    chk("stage_abort_pre", 32'(bus.rst_out), 32'hC);
    edges(1);
    chk("stage_abort_rst_out", 32'(bus.rst_out), 32'hF);
    chk("stage_abort_relock", 32'(bus.relock_cnt), 32'h3);
    edges(2);
    bus.locked = 1'b1;
    release_seq(1'b0);

    // Lock loss and soft request in the same cycle: one count.
    bus.locked = 1'b0;
    edges(2);
    bus.soft_req = 1'b1;
    edges(1);
    bus.soft_req = 1'b0;
    chk("both_rst_out", 32'(bus.rst_out), 32'hF);
    chk("both_relock", 32'(bus.relock_cnt), 32'h4);
    edges(3);
    chk("both_relock_later", 32'(bus.relock_cnt), 32'h4);

    // Repeated lock loss from HOLD until the counter saturates.
    for (int i = 0; i < 255; i++) begin
      bus.locked = 1'b1;
      edges(8);
      bus.locked = 1'b0;
      edges(4);
      if (i == 100) chk("sat_mid_relock", 32'(bus.relock_cnt), 32'd105);
    end
    chk("sat_relock", 32'(bus.relock_cnt), 32'd255);

    // Asynchronous reset pulse mid-HOLD, between clock edges.
    bus.locked = 1'b1;
    edges(10);
    chk("hold_state", 32'(bus.fsm_state), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out", 32'(bus.rst_out), 32'hF);
    chk("async_done", 32'(bus.done), 32'h0);
    chk("async_relock", 32'(bus.relock_cnt), 32'h0);
    chk("async_state", 32'(bus.fsm_state), 32'h0);
    #3 rst = 1'b0;
    release_seq(1'b1);
    chk("post_rst_relock", 32'(bus.relock_cnt), 32'h0);

    edges(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised power-on and lock-loss reset generator that follows the clock-wizard `locked` signal. It holds a bank of `N_OUT` active-high reset outputs asserted until `locked` has been stable for a filtered interval and a hold time has elapsed. It then releases the outputs one by one in index order, spaced by a fixed gap, so that downstream domains (ADC interface, channel processing, display) come out of reset in a defined order. It sits directly behind the clock generator and drives every block reset in the design.

## Interface
Parameters:
- `N_OUT`, default 4: number of staged reset outputs; must be ≥1.
- `SYNC_STAGES`, default 2: synchroniser depth for `locked`; must be ≥2.
- `LOCK_FILTER`, default 4: consecutive synchronised-high cycles of `locked` required before release starts; must be ≥1.
- `HOLD_CYCLES`, default 16: cycles from filter pass to release of `rst_out[0]`; must be ≥1.
- `STAGE_GAP`, default 8: cycles between release of `rst_out[k]` and `rst_out[k+1]`; must be ≥1.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `locked`  in  1  clock-wizard lock. Asynchronous to `clk`; synchronised internally.
- `soft_req`  in  1  synchronous single-cycle software reset request.
- `rst_out`  out  `N_OUT`  active-high staged resets. Assertion is immediate on `rst`; deassertion is synchronous.
- `done`  out  1  high while all `rst_out` bits are released.
- `relock_cnt`  out  8  count of lock-loss events, saturating at 255.

## Operation
- `rst` high, asynchronously: FSM=WAIT_LOCK, `rst_out`=all ones, `done`=0, `relock_cnt`=0, sync flops=0, counters=0, stage index=0.
- `locked` passes through a `SYNC_STAGES` flop chain. The last stage is `locked_s`.
- States:
  - WAIT_LOCK: the filter counter increments each cycle `locked_s`=1 and clears when `locked_s`=0. When the counter equals `LOCK_FILTER-1` and `locked_s`=1, go to HOLD and clear the counter.
  - HOLD: the counter increments. When it reaches `HOLD_CYCLES-1`, clear `rst_out[0]` and clear the counter. Go to STAGE with stage index=1, or go to RUN with `done`=1 if `N_OUT`=1.
  - STAGE: the counter increments. When it reaches `STAGE_GAP-1`, clear `rst_out[idx]` and increment idx. If idx was `N_OUT-1`, go to RUN and set `done`=1.
  - RUN: idle. `rst_out`=0, `done`=1.
- Abort conditions, each evaluated every cycle:
  - `locked_s`=0 in HOLD, STAGE or RUN: next edge goes to WAIT_LOCK with `rst_out`=all ones, `done`=0, counters and idx cleared. `relock_cnt` increments, saturating at 255.
  - `soft_req`=1 in any state: same abort, but `relock_cnt` is unchanged. In WAIT_LOCK it clears the filter counter.
  - If lock loss and `soft_req` occur in the same cycle, abort once and increment `relock_cnt` once.
- Priority: `rst` > abort > normal progression.
- Released outputs never reassert individually; reassertion always covers all bits.
- Counter width is `$clog2` of the largest of `LOCK_FILTER`, `HOLD_CYCLES`, `STAGE_GAP`, with a minimum of 1 bit.

## Timing
Edge numbering: edge 1 is the first rising edge at which `locked`=1 is sampled, with S=`SYNC_STAGES`, L=`LOCK_FILTER`, H=`HOLD_CYCLES`, G=`STAGE_GAP`.
- `locked_s` rises after edge S.
- HOLD is entered after edge S+L.
- `rst_out[0]` falls after edge S+L+H.
- `rst_out[k]` falls after edge S+L+H+k·G.
- `done` rises together with the fall of `rst_out[N_OUT-1]`.
- Defaults give falls after edges 22, 30, 38 and 46; `done` rises after edge 46.
- Lock loss: `locked` first sampled low at edge e gives `rst_out`=all ones after edge e+S.
- `soft_req` sampled high at edge e gives `rst_out`=all ones after edge e. If `locked_s` stays 1, the next release of `rst_out[0]` falls after edge e+L+H.
- `rst` reasserts outputs combinationally, with no clock needed.
- `done` and `rst_out` are registered, with no combinational path from any input except `rst`.

## Test plan
- Defaults, with `rst` released and then `locked` raised before edge 1 → `rst_out` reads 4'b1110 after edge 22, 4'b1100 after edge 30, 4'b1000 after edge 38, 4'b0000 with `done`=1 after edge 46, and `relock_cnt`=0.
- Glitch filter: `locked` high for 3 cycles, low for 1, then high permanently → no HOLD during the glitch; `rst_out[0]` falls 22 edges after the final rise.
- Lock loss in RUN: `locked` drops for 5 cycles → `rst_out`=4'hF and `done`=0 two edges after the drop, `relock_cnt`=1, and the full 22/30/38/46 sequence repeats from relock. Repeat 300 times → `relock_cnt` saturates at 255.
- Abort mid-STAGE: lock loss right after `rst_out[1]` releases → all bits reassert together and idx restarts at 0. `soft_req` together with lock loss in the same cycle → `relock_cnt` increments by 1 only.
- `soft_req` in RUN at edge e, `locked` steady → `rst_out`=4'hF after edge e, `rst_out[0]` falls after edge e+20, and `relock_cnt` is unchanged.
- `rst` pulse mid-HOLD, off-edge → `rst_out`=4'hF before the next clock edge, counters cleared, sequence restarts. Variant with `N_OUT`=1, H=3, L=1 → `rst_out` falls after edge 6 and `done` rises simultaneously.
